keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix keypad front end for the vending machine. Scans a 4x4 active-low key matrix, synchronises and debounces the row returns, and emits one 8-bit key code per press on `sel_item`. That output drives the vending controller's `sel_item` input directly. The code is a one-cycle pulse; between presses the output idles at `8'h00` (no selection).

## Interface
- `SCAN_DIV`, default 4: clock cycles per sample tick. Must be 2 or greater.
- `DEBOUNCE`, default 3: consecutive identical sample ticks required to accept a press or a release. Must be 1 or greater.
- `REPEAT_TICKS`, default 64: hold time before auto-repeat, in sample ticks. Used only under `KEYPAD_REPEAT_EN`.
- `clk`  in  1  single clock; all flops on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `row_in`  in  4  matrix rows, active-low, pulled up externally. Asynchronous to `clk`.
- `col_out`  out  4  column drive, active-low, one-hot-low.
- `sel_item`  out  8  key code, valid for one cycle. `8'h00` otherwise.
- `key_valid`  out  1  high in the same cycle that `sel_item` carries a code.
- `key_down`  out  1  high while an accepted key is held (EMIT and HOLD states).

## Operation
- `row_in` passes through a 2-flop synchroniser. All decisions use the synchronised value `rows_s`.
- `div_cnt` counts 0..`SCAN_DIV`-1 and wraps. A sample tick fires when `div_cnt` equals `SCAN_DIV`-1.
- Key map (row r, col c). Every code not listed here is never emitted.
  - r0: `1`=A1, `2`=A2, `3`=A3, `A`=BA
  - r1: `4`=A4, `5`=A5, `6`=A6, `B`=BB
  - r2: `7`=A7, `8`=A8, `9`=A9, `C`=0F (cancel)
  - r3: `*`=0D, `0`=A0, `#`=0E, `D`=BD
- SCAN state:
  - On each tick, if `rows_s` has exactly one low bit, latch row and column, set `stab_cnt`=1 and go to DEB. The column is not advanced.
  - Otherwise advance the column 0→1→2→3→0.
  - Zero low rows or two or more low rows (multi-key or ghosting) count as no key.
- DEB state:
  - Column held. On each tick, if `rows_s` equals the latched pattern, increment `stab_cnt`.
  - Any other pattern: return to SCAN and advance the column.
  - When `stab_cnt` reaches `DEBOUNCE`, go to EMIT.
  - With `DEBOUNCE`=1, go straight from SCAN to EMIT.
- EMIT state:
  - Lasts exactly one cycle: `sel_item`=code, `key_valid`=1, `key_down`=1.
  - Then go to HOLD with `rel_cnt`=0.
- HOLD state:
  - Column held. On each tick, all rows high increments `rel_cnt`; any row low clears it.
  - When `rel_cnt` reaches `DEBOUNCE`, return to SCAN and advance the column.
  - A second key pressed during HOLD is ignored. No code is ever emitted from HOLD unless `KEYPAD_REPEAT_EN` is defined.
- Only one code is emitted per accepted press, regardless of hold duration.

## Timing
- Reset values: `col_out`=4'b1110, `sel_item`=8'h00, `key_valid`=0, `key_down`=0. `div_cnt`, `stab_cnt` and `rel_cnt` are 0; state is SCAN; both synchroniser flops are 4'hF.
- Reset asserted mid-operation returns everything to the reset values within the same cycle (asynchronous). No partial code is emitted.
- The first tick after reset release occurs at the `SCAN_DIV`-th rising edge.
- `col_out` changes only on the clock edge after a tick, so each column settles for `SCAN_DIV`-1 cycles before it is sampled.
- Press-to-code latency, measured from a stable `row_in` edge: at most 2 + 4·`SCAN_DIV` + `DEBOUNCE`·`SCAN_DIV` + 1 cycles.
- Minimum gap between two codes: 1 + `DEBOUNCE`·`SCAN_DIV` cycles.
- `sel_item` and `key_valid` are registered outputs with no combinational path from `row_in`.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HOLD, a `rep_cnt` counts ticks with the latched key still present and clears whenever the latched key is absent.
  - When `rep_cnt` reaches `REPEAT_TICKS`, a one-cycle EMIT of the same code occurs and `rep_cnt` clears. The pulse repeats every `REPEAT_TICKS` ticks while the key is held.
  - Cancel (`0F`) never repeats.
- `KEYPAD_REPEAT_EN` undefined: `rep_cnt` logic is absent; one code per press only.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE`=3.
- Reset, then hold row0 low (key `1`, column 0) → `sel_item`=8'hA1 with `key_valid`=1 for exactly one cycle, within 31 cycles; `key_down` stays high until release.
- Press `#` (row3, column 2) for 200 cycles, release, then press `*` → exactly one 8'h0E pulse, then one 8'h0D pulse, with gap ≥ 13 cycles after release debounce.
- Glitch: row1 low for 6 cycles during column 1 → no code; SCAN resumes with the column advancing.
- Two rows low simultaneously (keys `2` and `5`) → no code ever; `col_out` keeps cycling.
- Assert `reset` low mid-DEB and mid-HOLD → outputs return to reset values immediately; no pulse after release until a fresh debounced press.
- With `KEYPAD_REPEAT_EN` and `REPEAT_TICKS`=8: hold `2` → 8'hA2 pulses every 32 cycles after the first. Hold `C` → a single 8'h0F pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with debounce; emits one key code pulse per press.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE     = 3,
    parameter int REPEAT_TICKS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [7:0] sel_item,
    output logic       key_valid,
    output logic       key_down
);

    localparam logic [1:0] ST_SCAN = 2'd0;
    localparam logic [1:0] ST_DEB  = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_TICKS);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
`else
    localparam int unused_repeat_ticks = REPEAT_TICKS;
`endif

    // Exactly one row pulled low; zero or several low rows are treated as no key.
    function automatic logic single_low(input logic [3:0] rows);
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
            default:                            single_low = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] rows);
        case (rows)
            4'b1110: row_index = 2'd0;
            4'b1101: row_index = 2'd1;
            4'b1011: row_index = 2'd2;
            4'b0111: row_index = 2'd3;
            default: row_index = 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] key_code(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: key_code = 8'hA1;
            4'h1: key_code = 8'hA2;
            4'h2: key_code = 8'hA3;
            4'h3: key_code = 8'hBA;
            4'h4: key_code = 8'hA4;
            4'h5: key_code = 8'hA5;
            4'h6: key_code = 8'hA6;
            4'h7: key_code = 8'hBB;
            4'h8: key_code = 8'hA7;
            4'h9: key_code = 8'hA8;
            4'hA: key_code = 8'hA9;
            4'hB: key_code = 8'h0F;
            4'hC: key_code = 8'h0D;
            4'hD: key_code = 8'hA0;
            4'hE: key_code = 8'h0E;
            4'hF: key_code = 8'hBD;
            default: key_code = 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        col_drive = ~(4'b0001 << col);
    endfunction

    logic [3:0]       sync1_r, sync2_r, rows_s;
    logic [DIV_W-1:0] div_cnt_r;
    logic             tick_s;
    logic [1:0]       state_r, state_nxt_s;
    logic [1:0]       col_idx_r, col_idx_nxt_s;
    logic [3:0]       row_lat_r, row_lat_nxt_s;
    logic [CNT_W-1:0] stab_cnt_r, stab_cnt_nxt_s, stab_inc_s;
    logic [CNT_W-1:0] rel_cnt_r, rel_cnt_nxt_s, rel_inc_s;
    logic [7:0]       code_s;
    logic [3:0]       col_out_r;
    logic [7:0]       sel_item_r;
    logic             key_valid_r, key_down_r;
`ifdef KEYPAD_REPEAT_EN
    logic [REP_W-1:0] rep_cnt_r, rep_cnt_nxt_s, rep_inc_s;
`endif

    assign rows_s     = sync2_r;
    assign tick_s     = (div_cnt_r == DIV_LAST);
    assign stab_inc_s = stab_cnt_r + CNT_ONE;
    assign rel_inc_s  = rel_cnt_r + CNT_ONE;
`ifdef KEYPAD_REPEAT_EN
    assign rep_inc_s  = rep_cnt_r + REP_ONE;
`endif

    // Two-flop synchroniser for the asynchronous row returns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 4'hF;
            sync2_r <= 4'hF;
        end else begin
            sync1_r <= row_in;
            sync2_r <= sync1_r;
        end
    end

    // Sample-tick divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r <= '0;
        end else if (tick_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
        end
    end

    // Scan / debounce / emit / hold next-state logic; all decisions happen on ticks.
    always_comb begin
        state_nxt_s    = state_r;
        col_idx_nxt_s  = col_idx_r;
        row_lat_nxt_s  = row_lat_r;
        stab_cnt_nxt_s = stab_cnt_r;
        rel_cnt_nxt_s  = rel_cnt_r;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_nxt_s  = rep_cnt_r;
`endif
        case (state_r)
            ST_SCAN: begin
                if (tick_s) begin
                    if (single_low(rows_s)) begin
                        row_lat_nxt_s  = rows_s;
                        stab_cnt_nxt_s = CNT_ONE;
                        state_nxt_s    = (CNT_ONE >= DEB_MAX) ? ST_EMIT : ST_DEB;
                    end else begin
                        col_idx_nxt_s = col_idx_r + 2'd1;
                    end
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_DEB: begin
                if (tick_s) begin
                    if (rows_s == row_lat_r) begin
                        stab_cnt_nxt_s = stab_inc_s;
                        state_nxt_s    = (stab_inc_s >= DEB_MAX) ? ST_EMIT : ST_DEB;
                    end else begin
                        stab_cnt_nxt_s = '0;
                        col_idx_nxt_s  = col_idx_r + 2'd1;
                        state_nxt_s    = ST_SCAN;
                    end
                end else begin
                    state_nxt_s = ST_DEB;
                end
            end
            ST_EMIT: begin
                state_nxt_s   = ST_HOLD;
                rel_cnt_nxt_s = '0;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt_nxt_s = '0;
`endif
            end
            ST_HOLD: begin
                if (tick_s) begin
                    if (rows_s == 4'hF) begin
                        if (rel_inc_s >= DEB_MAX) begin
                            rel_cnt_nxt_s = '0;
                            col_idx_nxt_s = col_idx_r + 2'd1;
                            state_nxt_s   = ST_SCAN;
                        end else begin
                            rel_cnt_nxt_s = rel_inc_s;
                        end
                    end else begin
                        rel_cnt_nxt_s = '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    // Re-emit while the latched key stays down; cancel is never repeated.
                    if (rows_s == row_lat_r) begin
                        if (rep_inc_s >= REP_MAX) begin
                            rep_cnt_nxt_s = '0;
                            if (key_code(row_index(row_lat_r), col_idx_r) != 8'h0F) begin
                                state_nxt_s = ST_EMIT;
                            end else begin
                                state_nxt_s = ST_HOLD;
                            end
                        end else begin
                            rep_cnt_nxt_s = rep_inc_s;
                        end
                    end else begin
                        rep_cnt_nxt_s = '0;
                    end
`endif
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s   = ST_SCAN;
                col_idx_nxt_s = 2'd0;
            end
        endcase
    end

    assign code_s = key_code(row_index(row_lat_nxt_s), col_idx_nxt_s);

    // FSM state and working registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_SCAN;
            col_idx_r  <= 2'd0;
            row_lat_r  <= 4'hF;
            stab_cnt_r <= '0;
            rel_cnt_r  <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_r  <= '0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            col_idx_r  <= col_idx_nxt_s;
            row_lat_r  <= row_lat_nxt_s;
            stab_cnt_r <= stab_cnt_nxt_s;
            rel_cnt_r  <= rel_cnt_nxt_s;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_r  <= rep_cnt_nxt_s;
`endif
        end
    end

    // Outputs are loaded from next-state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_out_r   <= 4'b1110;
            sel_item_r  <= 8'h00;
            key_valid_r <= 1'b0;
            key_down_r  <= 1'b0;
        end else begin
            col_out_r   <= col_drive(col_idx_nxt_s);
            sel_item_r  <= (state_nxt_s == ST_EMIT) ? code_s : 8'h00;
            key_valid_r <= (state_nxt_s == ST_EMIT);
            key_down_r  <= (state_nxt_s == ST_EMIT) || (state_nxt_s == ST_HOLD);
        end
    end

    assign col_out   = col_out_r;
    assign sel_item  = sel_item_r;
    assign key_valid = key_valid_r;
    assign key_down  = key_down_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix (SCAN_DIV=4, DEBOUNCE=3).
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [7:0] sel_item;
    logic       key_valid;
    logic       key_down;

    logic [15:0] keys;
    logic [3:0]  row_force_low;
    logic [3:0]  rows_model;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int idle_bad = 0;
    logic [7:0] pulses[$];
    int         pulse_cyc[$];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_TICKS(8)) dut (
        .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out),
        .sel_item(sel_item), .key_valid(key_valid), .key_down(key_down)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        rows_model = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) rows_model[r] = 1'b0;
            end
        end
    end
    assign row_in = rows_model & ~row_force_low;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_valid) begin
            pulses.push_back(sel_item);
            pulse_cyc.push_back(cyc);
        end else if (sel_item != 8'h00) begin
            idle_bad <= idle_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic wait_pulses(input int n, input int budget);
        for (int i = 0; i < budget && pulses.size() < n; i++) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && key_down; i++) @(negedge clk);
    endtask

    task automatic clear_pulses();
        pulses.delete();
        pulse_cyc.delete();
    endtask

    initial begin
        int lat;
        int found;
        int gap;
        logic [3:0] seen;
        logic [7:0] c0, c1;

        reset = 1'b0;
        keys = 16'h0000;
        row_force_low = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_col", col_out, 4'b1110);
        check("rst_sel", sel_item, 8'h00);
        check("rst_valid", key_valid, 1'b0);
        check("rst_down", key_down, 1'b0);

        // Key '1' held from reset release: tick at edge 4, accepted on third matching tick.
        keys[0] = 1'b1;
        reset = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (key_valid) begin
                lat = i;
                break;
            end
        end
        check("latency_1", lat, 12);
        check("code_1", sel_item, 8'hA1);
        check("down_emit", key_down, 1'b1);
        @(negedge clk);
        check("valid_one_cycle", key_valid, 1'b0);
        check("sel_idle", sel_item, 8'h00);
        check("down_hold", key_down, 1'b1);
        repeat (60) @(negedge clk);
        check("single_pulse_1", pulses.size(), 1);
        keys = 16'h0000;
        wait_idle(40);
        check("release_1", key_down, 1'b0);

        // '#' held long, released, then '*'.
        clear_pulses();
        keys[14] = 1'b1;
        repeat (200) @(negedge clk);
        keys = 16'h0000;
        wait_idle(40);
        check("release_hash", key_down, 1'b0);
        keys[12] = 1'b1;
        wait_pulses(2, 100);
        check("two_pulses", pulses.size(), 2);
        c0 = (pulses.size() > 0) ? pulses[0] : 8'hFF;
        c1 = (pulses.size() > 1) ? pulses[1] : 8'hFF;
        check("code_hash", c0, 8'h0E);
        check("code_star", c1, 8'h0D);
        gap = (pulse_cyc.size() > 1) ? (pulse_cyc[1] - pulse_cyc[0]) : 0;
        check("gap_ge13", (gap >= 13), 1'b1);
        keys = 16'h0000;
        wait_idle(40);

        // Six-cycle glitch on row1 while column 1 is driven.
        clear_pulses();
        for (int i = 0; i < 20 && col_out == 4'b1101; i++) @(negedge clk);
        for (int i = 0; i < 20 && col_out != 4'b1101; i++) @(negedge clk);
        row_force_low = 4'b0010;
        repeat (6) @(negedge clk);
        row_force_low = 4'h0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (col_out == 4'b1011) begin
                found = 1;
                break;
            end
        end
        check("glitch_col_adv", found, 1);
        repeat (20) @(negedge clk);
        check("glitch_no_code", pulses.size(), 0);

        // Keys '2' and '5' share column 1: two low rows is never a key.
        clear_pulses();
        keys[1] = 1'b1;
        keys[5] = 1'b1;
        seen = 4'h0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            seen = seen | ~col_out;
        end
        check("ghost_cols_cycle", seen, 4'hF);
        check("ghost_no_code", pulses.size(), 0);
        check("ghost_no_down", key_down, 1'b0);
        keys = 16'h0000;

        // Reset during debounce.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_pulses();
        keys[0] = 1'b1;
        reset = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        check("deb_rst_col", col_out, 4'b1110);
        check("deb_rst_down", key_down, 1'b0);
        keys = 16'h0000;
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("deb_rst_no_code", pulses.size(), 0);

        // Reset during hold.
        keys[0] = 1'b1;
        wait_pulses(1, 60);
        check("hold_pre_pulse", pulses.size(), 1);
        repeat (5) @(negedge clk);
        check("hold_pre_down", key_down, 1'b1);
        reset = 1'b0;
        #1;
        check("hold_rst_down", key_down, 1'b0);
        check("hold_rst_col", col_out, 4'b1110);
        check("hold_rst_sel", sel_item, 8'h00);
        check("hold_rst_valid", key_valid, 1'b0);
        keys = 16'h0000;
        @(negedge clk);
        reset = 1'b1;
        clear_pulses();
        repeat (40) @(negedge clk);
        check("hold_rst_no_code", pulses.size(), 0);
        keys[0] = 1'b1;
        wait_pulses(1, 60);
        check("fresh_press", pulses.size(), 1);
        c0 = (pulses.size() > 0) ? pulses[0] : 8'hFF;
        check("fresh_code", c0, 8'hA1);
        keys = 16'h0000;
        wait_idle(40);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat every 8 ticks on '2'; cancel 'C' fires once.
        clear_pulses();
        keys[1] = 1'b1;
        wait_pulses(3, 150);
        check("rep_count", pulses.size(), 3);
        gap = (pulse_cyc.size() > 2) ? (pulse_cyc[2] - pulse_cyc[1]) : 0;
        check("rep_period", gap, 32);
        c1 = (pulses.size() > 1) ? pulses[1] : 8'hFF;
        check("rep_code", c1, 8'hA2);
        keys = 16'h0000;
        wait_idle(40);
        clear_pulses();
        keys[11] = 1'b1;
        repeat (300) @(negedge clk);
        check("cancel_once", pulses.size(), 1);
        c0 = (pulses.size() > 0) ? pulses[0] : 8'hFF;
        check("cancel_code", c0, 8'h0F);
        keys = 16'h0000;
        wait_idle(40);
`endif

        check("idle_sel_zero", idle_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
